// File: rtl/dcache_pkg.sv
// Shared types and helpers for the data-cache to AXI4 bridge.
// Access-type encoding, burst constants and AXI length/size derivation.
package dcache_pkg;

  localparam logic [2:0] TYPE_B    = 3'd0;
  localparam logic [2:0] TYPE_H    = 3'd1;
  localparam logic [2:0] TYPE_W    = 3'd2;
  localparam logic [2:0] TYPE_D    = 3'd3;
  localparam logic [2:0] TYPE_LINE = 3'd4;

  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam int         LINE_BYTES     = 16;
  localparam int         LINE_OFF_W     = 4;

  typedef enum logic [1:0] {R_IDLE = 2'd0, R_AR = 2'd1, R_DATA = 2'd2} rd_state_e;
  typedef enum logic [1:0] {W_IDLE = 2'd0, W_SEND = 2'd1, W_RESP = 2'd2} wr_state_e;

  function automatic logic [7:0] len_of(input logic [2:0] t);
    return (t == TYPE_LINE) ? 8'd1 : 8'd0;
  endfunction

  // Lines move as two 8-byte beats; unknown encodings fall back to full width.
  function automatic logic [2:0] size_of(input logic [2:0] t);
    return (t <= TYPE_D) ? t : 3'd3;
  endfunction

endpackage

// File: rtl/dcache_axi_bridge_if.sv
// AXI4 master-side bus bundle used by the bridge (64-bit data, one ID bit-field).
interface dcache_axi_bridge_if #(parameter int ADDR_W = 32);
  logic              arvalid, arready;
  logic [ADDR_W-1:0] araddr;
  logic [3:0]        arid;
  logic [7:0]        arlen;
  logic [2:0]        arsize;
  logic [1:0]        arburst;
  logic              rvalid, rready, rlast;
  logic [63:0]       rdata;
  logic [1:0]        rresp;
  logic              awvalid, awready;
  logic [ADDR_W-1:0] awaddr;
  logic [3:0]        awid;
  logic [7:0]        awlen;
  logic [2:0]        awsize;
  logic [1:0]        awburst;
  logic              wvalid, wready, wlast;
  logic [63:0]       wdata;
  logic [7:0]        wstrb;
  logic              bvalid, bready;
  logic [1:0]        bresp;

  modport master (
    output arvalid, araddr, arid, arlen, arsize, arburst, input arready,
    input rvalid, rdata, rresp, rlast, output rready,
    output awvalid, awaddr, awid, awlen, awsize, awburst, input awready,
    output wvalid, wdata, wstrb, wlast, input wready,
    input bvalid, bresp, output bready
  );

  modport slave (
    input arvalid, araddr, arid, arlen, arsize, arburst, output arready,
    output rvalid, rdata, rresp, rlast, input rready,
    input awvalid, awaddr, awid, awlen, awsize, awburst, output awready,
    input wvalid, wdata, wstrb, wlast, output wready,
    output bvalid, bresp, input bready
  );
endinterface

// File: rtl/dcache_axi_bridge_axi_wr_channel.sv
// Write side of the bridge: latches one cache write and drives AW, W and B.
// AW and W complete independently; the response phase starts once both are done.
module axi_wr_channel
  import dcache_pkg::*;
#(
  parameter int         ADDR_W = 32,
  parameter logic [3:0] AXI_ID = 4'd0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_req,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [2:0]        wr_type,
  input  logic [127:0]      wdata,
  input  logic [7:0]        wstrb,
  output logic              wr_ready,
  output logic              busy,
  output logic [ADDR_W-1:0] pend_addr,
  output logic              err,
  dcache_axi_bridge_if.master m
);

  wr_state_e         state_q, state_d;
  logic [ADDR_W-1:0] awaddr_q, awaddr_d;
  logic [2:0]        wtype_q, wtype_d;
  logic [127:0]      wdata_q, wdata_d;
  logic [7:0]        wstrb_q, wstrb_d;
  logic              awvalid_q, awvalid_d, wvalid_q, wvalid_d;
  logic              aw_done_q, aw_done_d, w_done_q, w_done_d;
  logic              wbeat_q, wbeat_d;
  logic              aw_hs, w_hs, wlast_s, w_fin;

  assign aw_hs   = awvalid_q && m.awready;
  assign w_hs    = wvalid_q && m.wready;
  assign wlast_s = ({7'd0, wbeat_q} == len_of(wtype_q));
  assign w_fin   = w_hs && wlast_s;

  assign m.awvalid = awvalid_q;
  assign m.awaddr  = awaddr_q;
  assign m.awid    = AXI_ID;
  assign m.awlen   = len_of(wtype_q);
  assign m.awsize  = size_of(wtype_q);
  assign m.awburst = AXI_BURST_INCR;
  assign m.wvalid  = wvalid_q;
  assign m.wdata   = wbeat_q ? wdata_q[127:64] : wdata_q[63:0];
  assign m.wstrb   = (wtype_q == TYPE_LINE) ? 8'hFF : wstrb_q;
  assign m.wlast   = wlast_s;
  assign m.bready  = (state_q == W_RESP);

  assign wr_ready  = (state_q == W_IDLE);
  assign busy      = (state_q != W_IDLE);
  assign pend_addr = awaddr_q;
  assign err       = (state_q == W_RESP) && m.bvalid && (m.bresp != 2'b00);

  // Next-state and latch logic for the write channel.
  always_comb begin
    state_d   = state_q;
    awaddr_d  = awaddr_q;
    wtype_d   = wtype_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    awvalid_d = awvalid_q;
    wvalid_d  = wvalid_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;
    wbeat_d   = wbeat_q;
    case (state_q)
      W_IDLE: begin
        if (wr_req) begin
          awaddr_d  = (wr_type == TYPE_LINE) ?
                      {wr_addr[ADDR_W-1:LINE_OFF_W], {LINE_OFF_W{1'b0}}} : wr_addr;
          wtype_d   = wr_type;
          wdata_d   = wdata;
          wstrb_d   = wstrb;
          awvalid_d = 1'b1;
          wvalid_d  = 1'b1;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          wbeat_d   = 1'b0;
          state_d   = W_SEND;
        end else begin
          state_d   = W_IDLE;
        end
      end
      W_SEND: begin
        awvalid_d = awvalid_q && !aw_hs;
        aw_done_d = aw_done_q || aw_hs;
        wvalid_d  = wvalid_q && !w_fin;
        w_done_d  = w_done_q || w_fin;
        wbeat_d   = (w_hs && !wlast_s) ? 1'b1 : wbeat_q;
        if ((aw_done_q || aw_hs) && (w_done_q || w_fin)) begin
          state_d = W_RESP;
        end else begin
          state_d = W_SEND;
        end
      end
      W_RESP: begin
        if (m.bvalid) begin
          state_d = W_IDLE;
        end else begin
          state_d = W_RESP;
        end
      end
      default: begin
        state_d   = W_IDLE;
        awvalid_d = 1'b0;
        wvalid_d  = 1'b0;
      end
    endcase
  end

  // Write-channel state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= W_IDLE;
      awaddr_q  <= '0;
      wtype_q   <= 3'd0;
      wdata_q   <= 128'd0;
      wstrb_q   <= 8'd0;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
      wbeat_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      awaddr_q  <= awaddr_d;
      wtype_q   <= wtype_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      awvalid_q <= awvalid_d;
      wvalid_q  <= wvalid_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
      wbeat_q   <= wbeat_d;
    end
  end

endmodule

// File: rtl/dcache_axi_bridge.sv
// Data-cache to AXI4 master bridge: one outstanding read, one outstanding write.
// Reads wait only while a write to the same 16-byte line is in flight.
module dcache_axi_bridge
  import dcache_pkg::*;
#(
  parameter int         ADDR_W = 32,
  parameter logic [3:0] AXI_ID = 4'd0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          rd_req,
  input  logic [63:0]   rd_addr,
  input  logic [2:0]    rd_type,
  output logic          rd_ready,
  output logic [63:0]   rdata,
  output logic          rvalid,
  output logic          rlast,
  input  logic          wr_req,
  input  logic [63:0]   wr_addr,
  input  logic [2:0]    wr_type,
  input  logic [127:0]  wdata,
  input  logic [7:0]    wstrb,
  output logic          wr_ready,
  output logic          bus_err,
  dcache_axi_bridge_if.master m
);

  rd_state_e         r_state_q, r_state_d;
  logic [ADDR_W-1:0] araddr_q, araddr_d;
  logic [7:0]        arlen_q, arlen_d;
  logic [2:0]        arsize_q, arsize_d;
  logic              arvalid_q, arvalid_d;
  logic              rbeat_q, rbeat_d;
  logic              bus_err_q, bus_err_d;
  logic              wr_busy, wr_err, hazard, rd_acc, beat_last, r_err;
  logic [ADDR_W-1:0] wr_pend_addr;
  logic              unused_hi;

  assign unused_hi = ^{rd_addr[63:ADDR_W], wr_addr[63:ADDR_W]};

  axi_wr_channel #(.ADDR_W(ADDR_W), .AXI_ID(AXI_ID)) u_wr (
    .clk       (clk),
    .rst       (rst),
    .wr_req    (wr_req),
    .wr_addr   (wr_addr[ADDR_W-1:0]),
    .wr_type   (wr_type),
    .wdata     (wdata),
    .wstrb     (wstrb),
    .wr_ready  (wr_ready),
    .busy      (wr_busy),
    .pend_addr (wr_pend_addr),
    .err       (wr_err),
    .m         (m)
  );

  // A write accepted this very cycle also blocks a read to its line.
  assign hazard = (wr_busy && (rd_addr[ADDR_W-1:LINE_OFF_W] == wr_pend_addr[ADDR_W-1:LINE_OFF_W]))
               || (wr_req && wr_ready &&
                   (rd_addr[ADDR_W-1:LINE_OFF_W] == wr_addr[ADDR_W-1:LINE_OFF_W]));
  assign rd_ready  = (r_state_q == R_IDLE) && !hazard;
  assign rd_acc    = rd_req && rd_ready;
  assign beat_last = ({7'd0, rbeat_q} == arlen_q);

  assign rvalid  = (r_state_q == R_DATA) && m.rvalid;
  assign rdata   = m.rdata;
  assign rlast   = rvalid && beat_last;
  assign r_err   = rvalid && ((m.rlast != beat_last) || (m.rresp != 2'b00));
  assign bus_err = bus_err_q;

  assign m.arvalid = arvalid_q;
  assign m.araddr  = araddr_q;
  assign m.arid    = AXI_ID;
  assign m.arlen   = arlen_q;
  assign m.arsize  = arsize_q;
  assign m.arburst = AXI_BURST_INCR;
  assign m.rready  = (r_state_q == R_DATA);

  // Next-state logic for the read FSM and the sticky error flag.
  always_comb begin
    r_state_d = r_state_q;
    araddr_d  = araddr_q;
    arlen_d   = arlen_q;
    arsize_d  = arsize_q;
    arvalid_d = arvalid_q;
    rbeat_d   = rbeat_q;
    bus_err_d = bus_err_q || r_err || wr_err;
    case (r_state_q)
      R_IDLE: begin
        if (rd_acc) begin
          araddr_d  = (rd_type == TYPE_LINE) ?
                      {rd_addr[ADDR_W-1:LINE_OFF_W], {LINE_OFF_W{1'b0}}} : rd_addr[ADDR_W-1:0];
          arlen_d   = len_of(rd_type);
          arsize_d  = size_of(rd_type);
          arvalid_d = 1'b1;
          rbeat_d   = 1'b0;
          r_state_d = R_AR;
        end else begin
          r_state_d = R_IDLE;
        end
      end
      R_AR: begin
        if (m.arready) begin
          arvalid_d = 1'b0;
          r_state_d = R_DATA;
        end else begin
          r_state_d = R_AR;
        end
      end
      R_DATA: begin
        if (rvalid && beat_last) begin
          r_state_d = R_IDLE;
        end else if (rvalid) begin
          rbeat_d   = 1'b1;
        end else begin
          r_state_d = R_DATA;
        end
      end
      default: begin
        r_state_d = R_IDLE;
        arvalid_d = 1'b0;
      end
    endcase
  end

  // Read-side and error registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state_q <= R_IDLE;
      araddr_q  <= '0;
      arlen_q   <= 8'd0;
      arsize_q  <= 3'd0;
      arvalid_q <= 1'b0;
      rbeat_q   <= 1'b0;
      bus_err_q <= 1'b0;
    end else begin
      r_state_q <= r_state_d;
      araddr_q  <= araddr_d;
      arlen_q   <= arlen_d;
      arsize_q  <= arsize_d;
      arvalid_q <= arvalid_d;
      rbeat_q   <= rbeat_d;
      bus_err_q <= bus_err_d;
    end
  end

endmodule

// File: tb/tb_dcache_axi_bridge.sv
// Directed bench for dcache_axi_bridge; the bench itself plays the AXI slave.
module tb_dcache_axi_bridge;

  logic         clk = 1'b0;
  logic         rst;
  logic         rd_req, wr_req;
  logic [63:0]  rd_addr, wr_addr;
  logic [2:0]   rd_type, wr_type;
  logic [127:0] wdata;
  logic [7:0]   wstrb;
  logic         rd_ready, rvalid, rlast, wr_ready, bus_err;
  logic [63:0]  rdata;
  int           n_cmp = 0;
  int           n_err = 0;

  dcache_axi_bridge_if #(.ADDR_W(32)) axi ();

  dcache_axi_bridge #(.ADDR_W(32), .AXI_ID(4'd0)) dut (
    .clk(clk), .rst(rst),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_type(rd_type), .rd_ready(rd_ready),
    .rdata(rdata), .rvalid(rvalid), .rlast(rlast),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_type(wr_type), .wdata(wdata), .wstrb(wstrb),
    .wr_ready(wr_ready), .bus_err(bus_err), .m(axi)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1; rd_req = 1'b0; wr_req = 1'b0;
    rd_addr = 64'd0; wr_addr = 64'd0; rd_type = 3'd0; wr_type = 3'd0;
    wdata = 128'd0; wstrb = 8'd0;
    axi.arready = 1'b0; axi.rvalid = 1'b0; axi.rdata = 64'd0; axi.rresp = 2'b00; axi.rlast = 1'b0;
    axi.awready = 1'b0; axi.wready = 1'b0; axi.bvalid = 1'b0; axi.bresp = 2'b00;
    repeat (2) cyc();
    rst = 1'b0; #1;
    chk("rst_rd_ready", rd_ready, 1'b1);
    chk("rst_wr_ready", wr_ready, 1'b1);
    chk("rst_arvalid", axi.arvalid, 1'b0);
    chk("rst_awvalid", axi.awvalid, 1'b0);
    chk("rst_wvalid", axi.wvalid, 1'b0);
    chk("rst_rready", axi.rready, 1'b0);
    chk("rst_bready", axi.bready, 1'b0);
    chk("rst_bus_err", bus_err, 1'b0);

    // Line read
    rd_req = 1'b1; rd_addr = 64'h8000_1234; rd_type = 3'd4; #1;
    chk("lr_rd_ready", rd_ready, 1'b1);
    cyc(); rd_req = 1'b0; #1;
    chk("lr_arvalid", axi.arvalid, 1'b1);
    chk("lr_araddr", axi.araddr, 32'h8000_1230);
    chk("lr_arlen", axi.arlen, 8'd1);
    chk("lr_arsize", axi.arsize, 3'd3);
    chk("lr_arburst", axi.arburst, 2'b01);
    chk("lr_arid", axi.arid, 4'd0);
    chk("lr_busy_rd_ready", rd_ready, 1'b0);
    axi.arready = 1'b1; cyc(); axi.arready = 1'b0; #1;
    chk("lr_arvalid_drop", axi.arvalid, 1'b0);
    chk("lr_rready", axi.rready, 1'b1);
    axi.rvalid = 1'b1; axi.rdata = 64'h11; axi.rlast = 1'b0; #1;
    chk("lr_b0_rvalid", rvalid, 1'b1);
    chk("lr_b0_rdata", rdata, 64'h11);
    chk("lr_b0_rlast", rlast, 1'b0);
    cyc(); axi.rdata = 64'h22; axi.rlast = 1'b1; #1;
    chk("lr_b1_rvalid", rvalid, 1'b1);
    chk("lr_b1_rdata", rdata, 64'h22);
    chk("lr_b1_rlast", rlast, 1'b1);
    cyc(); axi.rvalid = 1'b0; axi.rlast = 1'b0; #1;
    chk("lr_rd_ready_back", rd_ready, 1'b1);
    chk("lr_bus_err", bus_err, 1'b0);

    // Byte read
    rd_req = 1'b1; rd_addr = 64'hA000_03F9; rd_type = 3'd0;
    cyc(); rd_req = 1'b0; #1;
    chk("br_araddr", axi.araddr, 32'hA000_03F9);
    chk("br_arlen", axi.arlen, 8'd0);
    chk("br_arsize", axi.arsize, 3'd0);
    axi.arready = 1'b1; cyc(); axi.arready = 1'b0;
    axi.rvalid = 1'b1; axi.rdata = 64'h5A; axi.rlast = 1'b1; #1;
    chk("br_rvalid", rvalid, 1'b1);
    chk("br_rlast", rlast, 1'b1);
    chk("br_rdata", rdata, 64'h5A);
    cyc(); axi.rvalid = 1'b0; axi.rlast = 1'b0; #1;
    chk("br_bus_err", bus_err, 1'b0);

    // Line write
    wr_req = 1'b1; wr_addr = 64'h8000_0104; wr_type = 3'd4;
    wdata = {64'hBBBB, 64'hAAAA}; wstrb = 8'h0F; #1;
    chk("lw_wr_ready", wr_ready, 1'b1);
    cyc(); wr_req = 1'b0; #1;
    chk("lw_wr_busy", wr_ready, 1'b0);
    chk("lw_awvalid", axi.awvalid, 1'b1);
    chk("lw_wvalid", axi.wvalid, 1'b1);
    chk("lw_awaddr", axi.awaddr, 32'h8000_0100);
    chk("lw_awlen", axi.awlen, 8'd1);
    chk("lw_awsize", axi.awsize, 3'd3);
    chk("lw_b0_wdata", axi.wdata, 64'hAAAA);
    chk("lw_b0_wstrb", axi.wstrb, 8'hFF);
    chk("lw_b0_wlast", axi.wlast, 1'b0);
    axi.awready = 1'b1; axi.wready = 1'b1; cyc(); axi.awready = 1'b0; #1;
    chk("lw_awvalid_drop", axi.awvalid, 1'b0);
    chk("lw_b1_wvalid", axi.wvalid, 1'b1);
    chk("lw_b1_wdata", axi.wdata, 64'hBBBB);
    chk("lw_b1_wlast", axi.wlast, 1'b1);
    cyc(); axi.wready = 1'b0; #1;
    chk("lw_wvalid_drop", axi.wvalid, 1'b0);
    chk("lw_bready", axi.bready, 1'b1);
    chk("lw_resp_wr_ready", wr_ready, 1'b0);
    cyc();
    chk("lw_wait_wr_ready", wr_ready, 1'b0);
    axi.bvalid = 1'b1; cyc(); axi.bvalid = 1'b0; #1;
    chk("lw_done_wr_ready", wr_ready, 1'b1);
    chk("lw_done_bready", axi.bready, 1'b0);

    // W completes three cycles before AW
    wr_req = 1'b1; wr_addr = 64'h8000_020C; wr_type = 3'd2;
    wdata = {64'd0, 64'h1122_3344_5566_7788}; wstrb = 8'hF0;
    cyc(); wr_req = 1'b0; #1;
    chk("wa_wdata", axi.wdata, 64'h1122_3344_5566_7788);
    chk("wa_wstrb", axi.wstrb, 8'hF0);
    chk("wa_wlast", axi.wlast, 1'b1);
    chk("wa_awsize", axi.awsize, 3'd2);
    axi.wready = 1'b1; cyc(); axi.wready = 1'b0; #1;
    for (int i = 0; i < 3; i++) begin
      chk("wa_wvalid_gone", axi.wvalid, 1'b0);
      chk("wa_awvalid_held", axi.awvalid, 1'b1);
      chk("wa_no_bready", axi.bready, 1'b0);
      if (i < 2) cyc();
    end
    axi.awready = 1'b1; cyc(); axi.awready = 1'b0; #1;
    chk("wa_bready", axi.bready, 1'b1);
    chk("wa_awvalid_drop", axi.awvalid, 1'b0);
    chk("wa_no_dup_beat", axi.wvalid, 1'b0);
    axi.bvalid = 1'b1; cyc(); axi.bvalid = 1'b0; #1;
    chk("wa_wr_ready", wr_ready, 1'b1);

    // Same-line hazard
    wr_req = 1'b1; wr_addr = 64'h8000_0040; wr_type = 3'd3; wstrb = 8'hFF;
    cyc(); wr_req = 1'b0;
    rd_req = 1'b1; rd_addr = 64'h8000_0048; rd_type = 3'd3; #1;
    chk("hz_blocked_send", rd_ready, 1'b0);
    cyc();
    chk("hz_no_arvalid", axi.arvalid, 1'b0);
    axi.awready = 1'b1; axi.wready = 1'b1; cyc(); axi.awready = 1'b0; axi.wready = 1'b0; #1;
    chk("hz_blocked_resp", rd_ready, 1'b0);
    axi.bvalid = 1'b1; #1;
    chk("hz_blocked_bvalid", rd_ready, 1'b0);
    cyc(); axi.bvalid = 1'b0; #1;
    chk("hz_released", rd_ready, 1'b1);
    cyc(); rd_req = 1'b0; #1;
    chk("hz_arvalid", axi.arvalid, 1'b1);
    chk("hz_araddr", axi.araddr, 32'h8000_0048);
    axi.arready = 1'b1; cyc(); axi.arready = 1'b0;
    axi.rvalid = 1'b1; axi.rlast = 1'b1; cyc(); axi.rvalid = 1'b0; axi.rlast = 1'b0;

    // Different line goes straight through
    wr_req = 1'b1; wr_addr = 64'h8000_0040; wr_type = 3'd3;
    cyc(); wr_req = 1'b0;
    rd_req = 1'b1; rd_addr = 64'h8000_0080; rd_type = 3'd3; #1;
    chk("nh_rd_ready", rd_ready, 1'b1);
    cyc(); rd_req = 1'b0; #1;
    chk("nh_araddr", axi.araddr, 32'h8000_0080);
    axi.arready = 1'b1; axi.awready = 1'b1; axi.wready = 1'b1;
    cyc(); axi.arready = 1'b0; axi.awready = 1'b0; axi.wready = 1'b0;
    axi.rvalid = 1'b1; axi.rlast = 1'b1; axi.bvalid = 1'b1;
    cyc(); axi.rvalid = 1'b0; axi.rlast = 1'b0; axi.bvalid = 1'b0; #1;
    chk("nh_idle_rd", rd_ready, 1'b1);
    chk("nh_idle_wr", wr_ready, 1'b1);

    // Simultaneous requests from idle
    wr_req = 1'b1; wr_addr = 64'h9000_0000; wr_type = 3'd3;
    rd_req = 1'b1; rd_addr = 64'h9000_0008; rd_type = 3'd3; #1;
    chk("sim_same_line_rd", rd_ready, 1'b0);
    chk("sim_same_line_wr", wr_ready, 1'b1);
    rd_addr = 64'h9000_0010; #1;
    chk("sim_diff_line_rd", rd_ready, 1'b1);
    cyc(); wr_req = 1'b0; rd_req = 1'b0; #1;
    chk("sim_arvalid", axi.arvalid, 1'b1);
    chk("sim_awvalid", axi.awvalid, 1'b1);
    chk("sim_araddr", axi.araddr, 32'h9000_0010);
    axi.arready = 1'b1; axi.awready = 1'b1; axi.wready = 1'b1;
    cyc(); axi.arready = 1'b0; axi.awready = 1'b0; axi.wready = 1'b0;
    axi.rvalid = 1'b1; axi.rlast = 1'b1; axi.bvalid = 1'b1;
    cyc(); axi.rvalid = 1'b0; axi.rlast = 1'b0; axi.bvalid = 1'b0; #1;
    chk("sim_done_rd", rd_ready, 1'b1);
    chk("sim_done_wr", wr_ready, 1'b1);
    chk("sim_bus_err", bus_err, 1'b0);

    // Error response is sticky until reset
    rd_req = 1'b1; rd_addr = 64'h0000_1000; rd_type = 3'd3;
    cyc(); rd_req = 1'b0;
    axi.arready = 1'b1; cyc(); axi.arready = 1'b0;
    axi.rvalid = 1'b1; axi.rdata = 64'hDEAD; axi.rresp = 2'b10; axi.rlast = 1'b1; #1;
    chk("er_rdata_fwd", rdata, 64'hDEAD);
    chk("er_rlast", rlast, 1'b1);
    cyc(); axi.rvalid = 1'b0; axi.rresp = 2'b00; axi.rlast = 1'b0; #1;
    chk("er_bus_err_set", bus_err, 1'b1);
    rd_req = 1'b1; rd_addr = 64'h0000_2000; rd_type = 3'd3;
    cyc(); rd_req = 1'b0;
    axi.arready = 1'b1; cyc(); axi.arready = 1'b0;
    axi.rvalid = 1'b1; axi.rlast = 1'b1; cyc(); axi.rvalid = 1'b0; axi.rlast = 1'b0; #1;
    chk("er_bus_err_sticky", bus_err, 1'b1);
    chk("er_rd_ready", rd_ready, 1'b1);
    rst = 1'b1; cyc(); rst = 1'b0; #1;
    chk("er_bus_err_cleared", bus_err, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
